// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared constants and enums for the UART frame parser          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_LEN_BAD  = 2'd0,
        ERR_NO_SPACE = 2'd1,
        ERR_CSUM_BAD = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } frame_err_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_frame_fifo : payload FIFO with speculative write pointer that is    |
// |                   committed or rolled back per frame                     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module uart_frame_fifo #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [8:0]                    wr_data_i,
    input  logic                          commit_i,
    input  logic                          rollback_i,
    input  logic                          rd_en_i,
    output logic [8:0]                    rd_data_o,
    output logic                          rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   free_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_spec_q;
    logic [AW:0] wr_commit_q;
    logic [AW:0] rd_ptr_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_spec_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
        end else begin
            if (rollback_i) begin
                wr_spec_q <= wr_commit_q;
            end else if (wr_en_i) begin
                wr_spec_q <= wr_spec_q + PTR_ONE;
            end
            if (commit_i) begin
                wr_commit_q <= wr_spec_q;
            end
            if (rd_en_i && rd_valid_o) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Only committed entries are visible; the head reads as zero when empty.
    assign rd_valid_o   = (rd_ptr_q != wr_commit_q);
    assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 9'h000;
    assign free_count_o = DEPTH_W - (wr_spec_q - rd_ptr_q);

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_frame_parser : extracts SOF/LEN/payload/CSUM frames from a UART     |
// |                     byte stream into a commit-on-good-checksum FIFO      |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module uart_frame_parser #(
    parameter int FIFO_DEPTH     = 64,
    parameter int MAX_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 104160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    import uart_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_ONE     = {{(TW-1){1'b0}}, 1'b1};

    frame_state_t   state_q, state_d;
    logic [7:0]     sum_q, sum_d;
    logic [7:0]     remaining_q, remaining_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic           frame_ok_q, frame_ok_d;
    logic           frame_err_q, frame_err_d;
    frame_err_t     err_code_q, err_code_d;

    logic           fifo_wr_en;
    logic           fifo_commit;
    logic           fifo_rollback;
    logic [8:0]     fifo_rd_data;
    logic [AW:0]    fifo_free;
    logic           timeout_fire;
    logic [7:0]     csum_total;

    uart_frame_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (fifo_wr_en),
        .wr_data_i    ({remaining_q == 8'd1, in_data}),
        .commit_i     (fifo_commit),
        .rollback_i   (fifo_rollback),
        .rd_en_i      (m_ready),
        .rd_data_o    (fifo_rd_data),
        .rd_valid_o   (m_valid),
        .free_count_o (fifo_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            sum_q       <= 8'h00;
            remaining_q <= 8'h00;
            idle_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_LEN_BAD;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            remaining_q <= remaining_d;
            idle_q      <= idle_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign csum_total = sum_q + in_data;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_fire = (state_q != ST_HUNT) && !in_valid && (idle_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        remaining_d   = remaining_q;
        idle_d        = idle_q + IDLE_ONE;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        fifo_wr_en    = 1'b0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;

        if (state_q == ST_HUNT || in_valid) begin
            idle_d = '0;
        end

        if (timeout_fire) begin
            fifo_rollback = 1'b1;
            frame_err_d   = 1'b1;
            err_code_d    = ERR_TIMEOUT;
            state_d       = ST_HUNT;
        end else if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_data == SOF_BYTE) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (in_data == 8'h00 || 32'(in_data) > MAX_LEN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN_BAD;
                        state_d     = ST_HUNT;
                    end else if (32'(in_data) > 32'(fifo_free)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_NO_SPACE;
                        state_d     = ST_HUNT;
                    end else begin
                        sum_d       = in_data;
                        remaining_d = in_data;
                        state_d     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    fifo_wr_en  = 1'b1;
                    sum_d       = sum_q + in_data;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (csum_total == 8'h00) begin
                        fifo_commit = 1'b1;
                        frame_ok_d  = 1'b1;
                    end else begin
                        fifo_rollback = 1'b1;
                        frame_err_d   = 1'b1;
                        err_code_d    = ERR_CSUM_BAD;
                    end
                    state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign m_data    = fifo_rd_data[7:0];
    assign m_last    = fifo_rd_data[8];
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
# uart_frame_parser

Consumes the byte stream produced by the UART receiver (`data_out`/`data_valid`) and extracts framed packets in the format SOF, LEN, payload, CSUM. Payload bytes are staged in an internal FIFO and become visible to the downstream consumer only after the checksum verifies. Bad, oversized, truncated or unbufferable frames are rolled back and reported. The block sits between `uart_rx` and the command/packet logic, and presents a valid/ready stream with a last-byte marker.

## Interface
- `FIFO_DEPTH`, 64: payload FIFO entries; power of 2, ≥ `MAX_LEN`.
- `MAX_LEN`, 32: largest legal LEN value; range 1..255.
- `TIMEOUT_CYCLES`, 104160: maximum idle gap between bytes inside a frame, in clocks (about 2 characters at 50 MHz / 9600 baud).
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_data`  in  8: received byte; wired to `uart_rx.data_out`.
- `in_valid`  in  1: one-cycle byte strobe; wired to `uart_rx.data_valid`. There is no backpressure.
- `m_data`  out  8: payload byte at the FIFO head.
- `m_last`  out  1: head byte is the final payload byte of its frame.
- `m_valid`  out  1: a committed byte is available.
- `m_ready`  in  1: consumer accepts; a pop occurs when `m_valid && m_ready`.
- `frame_ok`  out  1: one-cycle pulse when a frame is committed.
- `frame_err`  out  1: one-cycle pulse when a frame is dropped.
- `err_code`  out  2: reason for the drop, meaningful only with `frame_err`. 0 = LEN_BAD, 1 = NO_SPACE, 2 = CSUM_BAD, 3 = TIMEOUT.

## Operation
- Frame format: `0xA5`, LEN, LEN payload bytes, CSUM. The frame is valid when (LEN + Σpayload + CSUM) mod 256 == 0.
- State machine states: HUNT, LEN, PAYLOAD, CSUM. Each state advances only on `in_valid`, except for timeout.
- HUNT: a byte ≠ `0xA5` is discarded silently. `0xA5` moves the machine to LEN.
- LEN:
  - LEN == 0 or LEN > `MAX_LEN`: `frame_err`, code 0, go to HUNT.
  - LEN > free space: `frame_err`, code 1, go to HUNT.
  - Otherwise: `sum <= LEN`, `remaining <= LEN`, go to PAYLOAD.
- Free space is computed as `FIFO_DEPTH − (wr_spec − rd_ptr)`. All pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally.
- PAYLOAD: write {last, byte} at `wr_spec`, then `wr_spec++`. Update `sum += byte` as 8-bit wrapping arithmetic, and `remaining--`. `last` = (`remaining` == 1); that same byte moves the machine to CSUM.
- CSUM:
  - `sum + byte == 0`: `wr_commit <= wr_spec`, `frame_ok`.
  - Otherwise: `wr_spec <= wr_commit` (rollback), `frame_err`, code 2.
  - Both cases go to HUNT.
- Timeout: in LEN, PAYLOAD or CSUM, an idle counter counts cycles without `in_valid`. When it reaches `TIMEOUT_CYCLES`: rollback, `frame_err`, code 3, go to HUNT. In LEN state the rollback is a no-op. The counter clears on every `in_valid` and in HUNT.
- A `0xA5` byte inside LEN, PAYLOAD or CSUM is treated as ordinary data; there is no mid-frame resync.
- Consumer side: `m_valid = (rd_ptr != wr_commit)`. Uncommitted bytes are never visible.

## Timing
- Reset values: `m_valid`, `m_last`, `frame_ok` and `frame_err` are 0; `err_code` is 0; `m_data` is 0x00. All pointers are 0 and the state is HUNT.
- `frame_ok` / `frame_err` rise on the clock edge after the deciding `in_valid` cycle, or after the timeout expiry cycle.
- `m_valid` rises in the same cycle as `frame_ok`.
- `m_data` and `m_last` are a combinational read of the entry at `rd_ptr`. They stay stable while `m_valid && !m_ready`.
- Pop and commit in the same cycle: both take effect; `m_valid` reflects the new pointers on the next cycle.
- Pop and write in the same cycle: independent.
- Free space is computed with the pre-pop `rd_ptr`, which is conservative.
- `in_valid` on the cycle the timeout would fire: the byte wins and the counter clears.
- `rst` mid-frame: the partial frame is discarded and all committed data is lost. No error pulse is generated.

## Structure
- Package `uart_pkg`:
  - `SOF_BYTE` = 8'hA5.
  - Parser state enum `frame_state_t`.
  - Error enum `frame_err_t` (LEN_BAD, NO_SPACE, CSUM_BAD, TIMEOUT).
- Sub-module `uart_frame_fifo`: 9-bit-wide storage with `wr_spec`, `wr_commit` and `rd_ptr`, commit/rollback inputs, and a `free_count` output. The parser FSM, checksum logic and timeout counter live in the top module.

## Test plan
- Good frame: A5 03 11 22 33 97, with `m_ready`=1.
  - `frame_ok` pulses once.
  - Output is 11, 22, 33, with `m_last` asserted only on 33.
- Bad checksum: A5 03 11 22 33 98.
  - `frame_err` with code 2.
  - `m_valid` never asserts and the FIFO stays empty.
- Bad LEN: A5 00, then A5 21 (with `MAX_LEN`=32).
  - Two `frame_err` pulses, each with code 0.
  - A following good frame is accepted.
- Resync: 00 FF 5A, then A5 01 7E 81.
  - Leading junk is ignored and no error is reported.
  - `frame_ok`; output is 7E with `m_last`=1.
- Backpressure and full FIFO: `m_ready`=0, send two 32-byte good frames, then A5 01 ….
  - Third frame gets `frame_err` with code 1.
  - Raising `m_ready` drains exactly 64 bytes intact, with `m_last` at indices 31 and 63.
- Timeout and reset:
  - A5 02 10, then idle for `TIMEOUT_CYCLES`: `frame_err` with code 3 and no visible data.
  - Repeat with `rst` asserted mid-payload: outputs return to reset values and no pulse is generated.
